// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier producing the HI/LO pair.
// Handles MULT/MULTU plus MTHI/MTLO direct register writes.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic               go;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] res;

  assign go    = (state == IDLE) && start && !flush;
  assign mag_a = (sign && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sign && b[WIDTH-1]) ? -b : b;
  assign sum   = {1'b0, acc}
               + (mplier[0] ? {1'b0, mcand} : '0);
  assign prod  = {acc, mplier};
  assign res   = neg ? -prod : prod;
  assign busy  = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state decode; flush always returns to IDLE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (go) state_n = BUSY;
      BUSY: begin
        if (flush)              state_n = IDLE;
        else if (count == LAST) state_n = FIX;
      end
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture and one shift-add step per BUSY cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      count  <= '0;
    end else if (go) begin
      mcand  <= mag_a;
      mplier <= mag_b;
      acc    <= '0;
      neg    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
      count  <= '0;
    end else if (state == BUSY && !flush) begin
      {acc, mplier} <= {sum, mplier[WIDTH-1:1]};
      count         <= count + 1'b1;
    end
  end

  // HI/LO: the final product overrides coincident direct writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == FIX && !flush) begin
        {hi, lo} <= res;
        done     <= 1'b1;
      end else begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier with a cycle-level
// reference model compared on every falling edge.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sign  (sign),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] product(
    input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Reference: an operation takes 33 edges after the start edge.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_res = '0;
  int          m_left = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_res  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (hi_we) m_hi <= wdata;
      if (lo_we) m_lo <= wdata;
      if (m_busy) begin
        if (flush) begin
          m_busy <= 1'b0;
        end else if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start && !flush) begin
        m_res  <= product(sign, a, b);
        m_left <= 33;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mul(input string nm,
                        input logic s,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] eh,
                        input logic [31:0] el);
    int n;
    int nb;
    sign  = s;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
    sign  = ~s;
    a     = 32'hDEADBEEF;
    b     = 32'h0BADF00D;
    n  = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      step();
      n++;
    end
    check({nm, "_latency"}, 64'(n), 64'd33);
    check({nm, "_busycyc"}, 64'(nb), 64'd33);
    check({nm, "_hi"}, 64'(hi), 64'(eh));
    check({nm, "_lo"}, 64'(lo), 64'(el));
    step();
    check({nm, "_donepulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b1;
    step();

    do_mul("umax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001);
    do_mul("smix", 1'b1, 32'hFFFFFFFD, 32'd5,
           32'hFFFFFFFF, 32'hFFFFFFF1);
    do_mul("smin", 1'b1, 32'h80000000, 32'h80000000,
           32'h40000000, 32'h00000000);
    do_mul("umin", 1'b0, 32'h80000000, 32'h80000000,
           32'h40000000, 32'h00000000);

    hi_we = 1'b1;
    wdata = 32'h12345678;
    step();
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = 32'h9ABCDEF0;
    step();
    lo_we = 1'b0;
    check("pre_hi", 64'(hi), 64'h12345678);
    check("pre_lo", 64'(lo), 64'h9ABCDEF0);

    sign  = 1'b0;
    a     = 32'd7;
    b     = 32'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    a     = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("fl_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    begin
      int seen = 0;
      repeat (40) begin
        if (done) seen++;
        step();
      end
      check("fl_nodone", 64'(seen), 64'd0);
    end
    check("fl_hi", 64'(hi), 64'h12345678);
    check("fl_lo", 64'(lo), 64'h9ABCDEF0);

    a     = 32'h0000FFFF;
    b     = 32'h0000FFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    #2 rst = 1'b0;
    #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_hi", 64'(hi), 64'd0);
    check("mr_lo", 64'(lo), 64'd0);
    step();
    rst = 1'b1;
    step();

    do_mul("post", 1'b0, 32'h80000000, 32'd2,
           32'h00000001, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
